// File: rtl/port_alloc_rr_if.sv
// Allocator-side bundle between routing/retry logic (master) and port_alloc_rr (slave).
interface port_alloc_rr_if #(
   parameter int NUM_PORTS = 3,
   parameter int RW        = 2
);
   logic [NUM_PORTS*RW-1:0] route_req;
   logic [NUM_PORTS-1:0]    pkt_tail;
   logic [NUM_PORTS*RW-1:0] control;
   logic [NUM_PORTS-1:0]    grant;
   logic [NUM_PORTS-1:0]    fail;
   logic                    route_err;
   logic                    timeout_pulse;

   modport master (
      output route_req, pkt_tail,
      input  control, grant, fail, route_err, timeout_pulse
   );

   modport slave (
      input  route_req, pkt_tail,
      output control, grant, fail, route_err, timeout_pulse
   );
endinterface

// File: rtl/port_alloc_rr.sv
// Round-robin output-port allocator: each output locks to one input until its tail flit.
// Optional lock watchdog enabled by defining PORT_ALLOC_TIMEOUT_EN.
module port_alloc_rr #(
   parameter int NUM_PORTS = 3,
   parameter int RW        = 2,
   parameter int TIMEOUT   = 64
) (
   input  logic           clk,
   input  logic           rst_n,
   port_alloc_rr_if.slave bus
);
   localparam int PW = $clog2(NUM_PORTS);
   localparam logic [RW-1:0] MAX_CODE = RW'(NUM_PORTS);

   typedef enum logic {S_IDLE = 1'b0, S_LOCKED = 1'b1} state_t;

   state_t                  state_q  [NUM_PORTS];
   state_t                  state_d  [NUM_PORTS];
   logic [PW-1:0]           owner_q  [NUM_PORTS];
   logic [PW-1:0]           owner_d  [NUM_PORTS];
   logic [PW-1:0]           rr_ptr_q [NUM_PORTS];
   logic [PW-1:0]           rr_ptr_d [NUM_PORTS];
   logic [NUM_PORTS*RW-1:0] control_q, control_d;
   logic [NUM_PORTS-1:0]    grant_q, grant_d;
   logic [NUM_PORTS-1:0]    fail_q, fail_d;
   logic                    route_err_q, route_err_d;
   logic [NUM_PORTS-1:0]    won;
   logic [NUM_PORTS-1:0]    req_valid;
   logic [NUM_PORTS-1:0]    req_bad;
   logic [NUM_PORTS-1:0]    req_hit [NUM_PORTS];

   // req_hit[o][i]: input i is an eligible (unlocked) requester of output o
   for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_dec
      logic [RW-1:0] code;
      assign code          = bus.route_req[gi*RW +: RW];
      assign req_valid[gi] = (code != '0) && (code <= MAX_CODE);
      assign req_bad[gi]   = (code > MAX_CODE);
      for (genvar go = 0; go < NUM_PORTS; go++) begin : g_hit
         assign req_hit[go][gi] = (code == RW'(go + 1)) && !grant_q[gi];
      end
   end

`ifdef PORT_ALLOC_TIMEOUT_EN
   localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   logic [CW-1:0]        wd_cnt_q [NUM_PORTS];
   logic [CW-1:0]        wd_cnt_d [NUM_PORTS];
   logic                 timeout_q, timeout_d;
   logic [NUM_PORTS-1:0] wd_expire;

   for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_wd
      assign wd_expire[gi] = (wd_cnt_q[gi] == CW'(TIMEOUT - 1));
   end
   assign bus.timeout_pulse = timeout_q;
`else
   logic unused_timeout;
   assign unused_timeout    = (TIMEOUT > 0);
   assign bus.timeout_pulse = 1'b0;
`endif

   always_comb begin
      int   idx;
      logic found;
      idx         = 0;
      found       = 1'b0;
      state_d     = state_q;
      owner_d     = owner_q;
      rr_ptr_d    = rr_ptr_q;
      won         = '0;
      grant_d     = '0;
      control_d   = '0;
      route_err_d = |req_bad;
`ifdef PORT_ALLOC_TIMEOUT_EN
      wd_cnt_d    = wd_cnt_q;
      timeout_d   = 1'b0;
`endif
      for (int o = 0; o < NUM_PORTS; o++) begin
         if (state_q[o] == S_LOCKED) begin
            if (bus.pkt_tail[owner_q[o]]) begin
               state_d[o] = S_IDLE;
            end
`ifdef PORT_ALLOC_TIMEOUT_EN
            else if (wd_expire[o]) begin
               state_d[o] = S_IDLE;
               timeout_d  = 1'b1;
            end else begin
               wd_cnt_d[o] = CW'(wd_cnt_q[o] + 1'b1);
            end
`endif
         end else begin
            found = 1'b0;
            for (int k = 0; k < NUM_PORTS; k++) begin
               idx = int'(rr_ptr_q[o]) + k;
               if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
               if (!found && req_hit[o][idx]) begin
                  found       = 1'b1;
                  state_d[o]  = S_LOCKED;
                  owner_d[o]  = PW'(idx);
                  rr_ptr_d[o] = (idx == NUM_PORTS - 1) ? '0 : PW'(idx + 1);
                  won[idx]    = 1'b1;
`ifdef PORT_ALLOC_TIMEOUT_EN
                  wd_cnt_d[o] = '0;
`endif
               end
            end
         end
         // Outputs reflect the post-edge lock state, so grant/control are registered views of it
         if (state_d[o] == S_LOCKED) begin
            grant_d[owner_d[o]]     = 1'b1;
            control_d[o*RW +: RW]   = RW'(int'(owner_d[o]) + 1);
         end
      end
      fail_d = req_valid & ~grant_q & ~won;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int o = 0; o < NUM_PORTS; o++) begin
            state_q[o]  <= S_IDLE;
            owner_q[o]  <= '0;
            rr_ptr_q[o] <= '0;
`ifdef PORT_ALLOC_TIMEOUT_EN
            wd_cnt_q[o] <= '0;
`endif
         end
         control_q   <= '0;
         grant_q     <= '0;
         fail_q      <= '0;
         route_err_q <= 1'b0;
`ifdef PORT_ALLOC_TIMEOUT_EN
         timeout_q   <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         rr_ptr_q    <= rr_ptr_d;
         control_q   <= control_d;
         grant_q     <= grant_d;
         fail_q      <= fail_d;
         route_err_q <= route_err_d;
`ifdef PORT_ALLOC_TIMEOUT_EN
         wd_cnt_q    <= wd_cnt_d;
         timeout_q   <= timeout_d;
`endif
      end
   end

   assign bus.control   = control_q;
   assign bus.grant     = grant_q;
   assign bus.fail      = fail_q;
   assign bus.route_err = route_err_q;
endmodule
